// File: rtl/decoder_main.sv
// rtl/decoder_main.sv - constant-weight 18-9 gap decoder with its best_d helper.
// Optional gap range check (dec_err) enabled by defining DEC_CHECK_EN.

module best_d (
    input  logic        clk,
    input  logic [18:0] n,
    input  logic [3:0]  t,
    output logic [17:0] d,
    output logic [4:0]  u
);
    logic [18:0] n_q;
    logic [3:0]  t_q;
    logic [4:0]  u_c;

    // Largest u in 0..17 with t*2^u <= n; u=0 when no candidate qualifies.
    always_comb begin
        u_c = '0;
        for (int i = 0; i < 18; i++) begin
            if (({19'b0, t_q} << i) <= {4'b0, n_q})
                u_c = 5'(i);
        end
    end

    always_ff @(posedge clk) begin
        n_q <= n;
        t_q <= t;
        u   <= u_c;
        d   <= 18'(1) << u_c;
    end
endmodule

module decoder_main #(
    parameter int N_INIT = 262144,
    parameter int T_INIT = 9,
    parameter int GAP_W  = 18
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [GAP_W-1:0] cw_word,
    input  logic             cw_valid,
    output logic             cw_ack,
    output logic             bin_msg,
    output logic             writefifo,
    input  logic             fifofull,
    output logic             ready,
    output logic             done,
    output logic             dec_err
);
    typedef enum logic [3:0] {
        S_IDLE, S_GET, S_BEST, S_CMP, S_ONE, S_ZERO, S_SUFX, S_UPD, S_SKIP, S_FIN
    } state_t;

    state_t           state;
    logic [18:0]      n;
    logic [3:0]       t;
    logic [GAP_W-1:0] g;
    logic [4:0]       k;
    logic             settle;
    logic [17:0]      d;
    logic [4:0]       u;
    logic [18:0]      g19;
    logic [18:0]      d19;

    assign g19 = 19'(g);
    assign d19 = {1'b0, d};

    best_d u_best_d (
        .clk (clk),
        .n   (n),
        .t   (t),
        .d   (d),
        .u   (u)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= S_IDLE;
            n      <= 19'(N_INIT);
            t      <= 4'(T_INIT);
            g      <= '0;
            k      <= '0;
            settle <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    n     <= 19'(N_INIT);
                    t     <= 4'(T_INIT);
                    state <= S_GET;
                end
                S_GET: if (cw_valid) begin
                    g      <= cw_word;
                    settle <= 1'b0;
                    state  <= (n <= 19'(t)) ? S_SKIP : S_BEST;
                end
                // best_d is two registers deep; wait for it to reflect the current n,t.
                S_BEST: begin
                    settle <= 1'b1;
                    if (settle)
                        state <= S_CMP;
                end
                S_CMP: state <= (g19 >= d19) ? S_ONE : S_ZERO;
                S_ONE: if (!fifofull) begin
                    g      <= GAP_W'(g19 - d19);
                    n      <= n - d19;
                    settle <= 1'b0;
                    state  <= S_BEST;
                end
                S_ZERO: if (!fifofull) begin
                    k     <= u;
                    state <= (u == 5'd0) ? S_UPD : S_SUFX;
                end
                S_SUFX: if (!fifofull) begin
                    k <= k - 5'd1;
                    if (k == 5'd1)
                        state <= S_UPD;
                end
                S_UPD: begin
                    n     <= n - g19 - 19'd1;
                    t     <= t - 4'd1;
                    state <= (t == 4'd1) ? S_FIN : S_GET;
                end
                S_SKIP: begin
                    n     <= n - 19'd1;
                    t     <= t - 4'd1;
                    state <= (t == 4'd1) ? S_FIN : S_GET;
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        writefifo = 1'b0;
        bin_msg   = 1'b0;
        case (state)
            S_ONE: begin
                writefifo = !fifofull;
                bin_msg   = 1'b1;
            end
            S_ZERO: writefifo = !fifofull;
            S_SUFX: begin
                writefifo = !fifofull;
                bin_msg   = g[k - 5'd1];
            end
            default: ;
        endcase
    end

    assign cw_ack = (state == S_UPD) || (state == S_SKIP);
    assign ready  = cw_ack;
    assign done   = (state == S_FIN);

`ifdef DEC_CHECK_EN
    logic err_q;

    // g > n-t evaluated as g+t > n so a small n cannot wrap the comparison.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            err_q <= 1'b0;
        else if (state == S_IDLE && start)
            err_q <= 1'b0;
        else if (state == S_UPD && (({1'b0, g19} + 20'(t)) > {1'b0, n}))
            err_q <= 1'b1;
        else if (state == S_SKIP && g != '0)
            err_q <= 1'b1;
    end

    assign dec_err = err_q;
`else
    assign dec_err = 1'b0;
`endif
endmodule

// File: tb/tb_decoder_main.sv
// tb/tb_decoder_main.sv - self-checking bench for decoder_main against a gap-level reference model.
module tb_decoder_main;
    localparam int N_INIT = 262144;
    localparam int T_INIT = 9;
    localparam int NG     = 9;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        start = 1'b0;
    logic [17:0] cw_word = '0;
    logic        cw_valid = 1'b0;
    logic        fifofull = 1'b0;
    logic        cw_ack, bin_msg, writefifo, ready, done, dec_err;

    always #5 clk = ~clk;

    decoder_main #(.N_INIT(N_INIT), .T_INIT(T_INIT), .GAP_W(18)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .cw_word(cw_word), .cw_valid(cw_valid),
        .cw_ack(cw_ack), .bin_msg(bin_msg), .writefifo(writefifo), .fifofull(fifofull),
        .ready(ready), .done(done), .dec_err(dec_err)
    );

    int n_checks = 0;
    int n_fail = 0;
    int gaps[NG];
    int exp_bits[$];
    int got_bits[$];
    bit exp_err;
    int mn, mt;
    int n_ready, n_ack, n_done, viol;
    bit tmo;

    function automatic int model_u(int n, int t);
        int u = 0;
        while (u < 17 && t * (1 << (u + 1)) <= n) u++;
        return u;
    endfunction

    task automatic model_start();
        mn = N_INIT;
        mt = T_INIT;
        exp_bits.delete();
        exp_err = 1'b0;
    endtask

    task automatic model_gap(input int g_in);
        int g = g_in;
        int u, d;
        bit fin = 1'b0;
        if (mn <= mt) begin
            if (g != 0) exp_err = 1'b1;
            mn = (mn - 1) & 32'h7FFFF;
            mt = mt - 1;
            return;
        end
        while (!fin) begin
            u = model_u(mn, mt);
            d = 1 << u;
            if (g >= d) begin
                exp_bits.push_back(1);
                g  = g - d;
                mn = mn - d;
            end else begin
                exp_bits.push_back(0);
                for (int b = u - 1; b >= 0; b--) exp_bits.push_back((g >> b) & 1);
                if (g > mn - mt) exp_err = 1'b1;
                mn  = (mn - g - 1) & 32'h7FFFF;
                mt  = mt - 1;
                fin = 1'b1;
            end
        end
    endtask

    task automatic build_model();
        model_start();
        for (int i = 0; i < NG; i++) model_gap(gaps[i]);
    endtask

    // Valid gaps (never more than the remaining room n-t); first_gap >= 0 forces gap 0.
    task automatic gen_random_gaps(input int first_gap);
        model_start();
        for (int i = 0; i < NG; i++) begin
            int g, room, d;
            if (mn <= mt) g = 0;
            else begin
                room = mn - mt;
                d = 1 << model_u(mn, mt);
                case ($urandom % 4)
                    0: g = 0;
                    1: g = int'($urandom_range(0, 3 * d));
                    2: g = int'($urandom_range(0, room));
                    default: g = int'($urandom % 64);
                endcase
                if (g > room) g = room;
            end
            if (i == 0 && first_gap >= 0) g = first_gap;
            gaps[i] = g;
            model_gap(g);
        end
    endtask

    // ff_mode: 0 never full, 1 random full, 2 full for 10 cycles after the first bit.
    task automatic run_block(input int ff_mode, input int stop_after, input bit noisy);
        int idx = 0;
        bit pres = 1'b0;
        int hold = 0;
        bit armed = 1'b0;
        got_bits.delete();
        n_ready = 0; n_ack = 0; n_done = 0; viol = 0; tmo = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            start = (cyc == 0) || (noisy && ($urandom % 16 == 0));
            if (!pres && idx < NG && ($urandom % 4) != 0) pres = 1'b1;
            cw_valid = pres;
            cw_word  = 18'(gaps[(idx < NG) ? idx : NG - 1]);
            case (ff_mode)
                1: fifofull = ($urandom % 4 == 0);
                2: begin
                    fifofull = (hold > 0);
                    if (hold > 0) hold--;
                end
                default: fifofull = 1'b0;
            endcase
            #1;
            if (writefifo) begin
                got_bits.push_back(int'(bin_msg));
                if (fifofull) viol++;
                if (ff_mode == 2 && !armed) begin
                    armed = 1'b1;
                    hold = 10;
                end
            end
            if (cw_ack) begin
                n_ack++;
                pres = 1'b0;
                idx++;
            end
            if (ready) n_ready++;
            if (done) n_done++;
            if (done || (stop_after > 0 && got_bits.size() >= stop_after)) begin
                tmo = 1'b0;
                break;
            end
        end
        start = 1'b0;
        fifofull = 1'b0;
        if (stop_after == 0) begin
            cw_valid = 1'b0;
            repeat (3) begin
                @(negedge clk);
                #1;
                if (done) n_done++;
                if (ready) n_ready++;
                if (writefifo) viol++;
            end
        end
    endtask

    task automatic test_reset();
        bit bad = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({cw_ack, bin_msg, writefifo, ready, done, dec_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 000000",
                     {cw_ack, bin_msg, writefifo, ready, done, dec_err});
        end
        rst_b = 1'b1;
        cw_valid = 1'b1;
        cw_word = 18'd7;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (cw_ack || writefifo || ready || done) bad = 1'b1;
        end
        cw_valid = 1'b0;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL idle_without_start: got activity=1, required 0");
        end
    endtask

    task automatic test_reset_mid_sufx();
        bit mism = 1'b0;
        for (int i = 0; i < NG; i++) gaps[i] = 0;
        run_block(0, 3, 1'b0);
        n_checks++;
        if (tmo) begin
            n_fail++;
            $display("FAIL mid_sufx_reach: got timeout=1, required 0");
        end
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        n_checks++;
        if ({cw_ack, bin_msg, writefifo, ready, done, dec_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_sufx: got %b, required 000000",
                     {cw_ack, bin_msg, writefifo, ready, done, dec_err});
        end
        @(negedge clk);
        rst_b = 1'b1;
        cw_valid = 1'b0;
        gen_random_gaps(-1);
        run_block(0, 0, 1'b0);
        if (got_bits.size() != exp_bits.size()) mism = 1'b1;
        else foreach (exp_bits[i]) if (got_bits[i] !== exp_bits[i]) mism = 1'b1;
        n_checks++;
        if (mism) begin
            n_fail++;
            $display("FAIL post_reset_bits: got %0d bits, required %0d bits (or content differs)",
                     got_bits.size(), exp_bits.size());
        end
        n_checks++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL post_reset_done: got %0d, required 1", n_done);
        end
    endtask

    task automatic test_all_zero();
        bit mism = 1'b0;
        for (int i = 0; i < NG; i++) gaps[i] = 0;
        build_model();
        run_block(0, 0, 1'b0);
        if (got_bits.size() != exp_bits.size()) mism = 1'b1;
        else foreach (exp_bits[i]) if (got_bits[i] !== 0) mism = 1'b1;
        n_checks++;
        if (mism) begin
            n_fail++;
            $display("FAIL zero_bits: got %0d bits, required %0d zero bits", got_bits.size(), exp_bits.size());
        end
        n_checks++;
        if (n_ready !== NG || n_ack !== NG) begin
            n_fail++;
            $display("FAIL zero_ready_ack: got ready=%0d ack=%0d, required %0d", n_ready, n_ack, NG);
        end
        n_checks++;
        if (n_done !== 1 || tmo) begin
            n_fail++;
            $display("FAIL zero_done: got done=%0d timeout=%0d, required 1 and 0", n_done, tmo);
        end
    endtask

    task automatic test_one_then_suffix();
        bit mism = 1'b0;
        int d0, u1, sfx;
        d0 = 1 << model_u(N_INIT, T_INIT);
        u1 = model_u(N_INIT - d0, T_INIT);
        gaps[0] = d0 + 5;
        for (int i = 1; i < NG; i++) gaps[i] = 0;
        build_model();
        run_block(0, 0, 1'b0);
        if (got_bits.size() != exp_bits.size()) mism = 1'b1;
        else foreach (exp_bits[i]) if (got_bits[i] !== exp_bits[i]) mism = 1'b1;
        n_checks++;
        if (mism) begin
            n_fail++;
            $display("FAIL one_sfx_bits: got %0d bits, required %0d bits (or content differs)",
                     got_bits.size(), exp_bits.size());
        end
        sfx = -1;
        if (got_bits.size() >= 2 + u1) begin
            sfx = 0;
            for (int i = 0; i < u1; i++) sfx = (sfx << 1) | got_bits[2 + i];
        end
        n_checks++;
        if (got_bits.size() < 2 || got_bits[0] !== 1 || got_bits[1] !== 0 || sfx !== 5) begin
            n_fail++;
            $display("FAIL one_sfx_prefix: got first=%0d second=%0d suffix=%0d, required 1 0 5",
                     (got_bits.size() > 0) ? got_bits[0] : -1,
                     (got_bits.size() > 1) ? got_bits[1] : -1, sfx);
        end
    endtask

    task automatic test_fifofull_stall();
        bit mism = 1'b0;
        gen_random_gaps(5);
        run_block(2, 0, 1'b0);
        if (got_bits.size() != exp_bits.size()) mism = 1'b1;
        else foreach (exp_bits[i]) if (got_bits[i] !== exp_bits[i]) mism = 1'b1;
        n_checks++;
        if (mism) begin
            n_fail++;
            $display("FAIL stall_bits: got %0d bits, required %0d bits (or content differs)",
                     got_bits.size(), exp_bits.size());
        end
        n_checks++;
        if (viol !== 0 || n_done !== 1) begin
            n_fail++;
            $display("FAIL stall_protocol: got violations=%0d done=%0d, required 0 and 1", viol, n_done);
        end
    endtask

    task automatic test_back_to_back();
        for (int blk = 0; blk < 20; blk++) begin
            bit mism = 1'b0;
            gen_random_gaps(-1);
            run_block(1, 0, 1'b1);
            if (got_bits.size() != exp_bits.size()) mism = 1'b1;
            else foreach (exp_bits[i]) if (got_bits[i] !== exp_bits[i]) mism = 1'b1;
            n_checks++;
            if (mism) begin
                n_fail++;
                $display("FAIL random_block_%0d_bits: got %0d bits, required %0d bits (or content differs)",
                         blk, got_bits.size(), exp_bits.size());
            end
            n_checks++;
            if (n_done !== 1 || n_ack !== NG || n_ready !== NG || viol !== 0) begin
                n_fail++;
                $display("FAIL random_block_%0d_handshake: got done=%0d ack=%0d ready=%0d viol=%0d, required 1 %0d %0d 0",
                         blk, n_done, n_ack, n_ready, viol, NG, NG);
            end
        end
    endtask

    task automatic test_dec_check();
        bit mism = 1'b0;
        bit want;
        gaps[0] = N_INIT - T_INIT + 1;
        for (int i = 1; i < NG; i++) gaps[i] = 0;
        build_model();
`ifdef DEC_CHECK_EN
        want = exp_err;
`else
        want = 1'b0;
`endif
        run_block(0, 0, 1'b0);
        if (got_bits.size() != exp_bits.size()) mism = 1'b1;
        else foreach (exp_bits[i]) if (got_bits[i] !== exp_bits[i]) mism = 1'b1;
        n_checks++;
        if (mism) begin
            n_fail++;
            $display("FAIL overflow_bits: got %0d bits, required %0d bits (or content differs)",
                     got_bits.size(), exp_bits.size());
        end
        n_checks++;
        if (dec_err !== want || n_done !== 1) begin
            n_fail++;
            $display("FAIL overflow_dec_err: got dec_err=%0d done=%0d, required %0d and 1", dec_err, n_done, want);
        end
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (dec_err !== want) begin
            n_fail++;
            $display("FAIL dec_err_sticky: got %0d, required %0d", dec_err, want);
        end
        for (int i = 0; i < NG; i++) gaps[i] = 0;
        build_model();
        run_block(0, 0, 1'b0);
        n_checks++;
        if (dec_err !== exp_err) begin
            n_fail++;
            $display("FAIL dec_err_cleared: got %0d, required %0d", dec_err, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_one_then_suffix();
        test_reset_mid_sufx();
        test_fifofull_stall();
        test_back_to_back();
        test_dec_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
